// File: rtl/qsfp_link_pkg.sv
// Shared types for the QSFP28 cage sequencer: state codes, pin bundle and
// the per-state pin decode.
package qsfp_link_pkg;

  typedef enum logic [2:0] {
    ST_ABSENT     = 3'd0,
    ST_REFCLK_RST = 3'd1,
    ST_MOD_RST    = 3'd2,
    ST_INIT_WAIT  = 3'd3,
    ST_CLK_WAIT   = 3'd4,
    ST_GT_RST     = 3'd5,
    ST_RUN        = 3'd6,
    ST_FAULT      = 3'd7
  } state_t;

  typedef struct packed {
    logic resetl;
    logic lpmode;
    logic modsell;
    logic refclk_reset;
    logic gt_reset;
    logic ready;
    logic fault;
  } pins_t;

  // Safe pin levels: module held in reset, low power, deselected.
  localparam pins_t PINS_RESET = '{
    resetl:       1'b0,
    lpmode:       1'b1,
    modsell:      1'b1,
    refclk_reset: 1'b1,
    gt_reset:     1'b1,
    ready:        1'b0,
    fault:        1'b0
  };

  function automatic pins_t pins_for(state_t s);
    pins_t p;
    p = PINS_RESET;
    case (s)
      ST_ABSENT, ST_REFCLK_RST: p = PINS_RESET;
      ST_MOD_RST: p.refclk_reset = 1'b0;
      ST_INIT_WAIT, ST_CLK_WAIT, ST_GT_RST: begin
        p.resetl       = 1'b1;
        p.lpmode       = 1'b0;
        p.refclk_reset = 1'b0;
      end
      ST_RUN: begin
        p.resetl       = 1'b1;
        p.lpmode       = 1'b0;
        p.refclk_reset = 1'b0;
        p.gt_reset     = 1'b0;
        p.modsell      = 1'b0;
        p.ready        = 1'b1;
      end
      ST_FAULT: begin
        p.resetl       = 1'b1;
        p.lpmode       = 1'b0;
        p.refclk_reset = 1'b0;
        p.fault        = 1'b1;
      end
      default: p = PINS_RESET;
    endcase
    return p;
  endfunction

  function automatic int max_int(int a, int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/qsfp_link_sequencer_if.sv
// QSFP28 cage sideband pins as seen between the sequencer (master) and the
// board/module (slave).
interface qsfp_link_sequencer_if;
  // Plain level signals, no valid/ready handshake: modprsl and intl are
  // asynchronous module outputs, everything else is a registered level
  // driven by the sequencer.
  logic       modprsl;
  logic       intl;
  logic       resetl;
  logic       lpmode;
  logic       modsell;
  logic       refclk_reset;
  logic [1:0] fs;

  modport master (
    input  modprsl, intl,
    output resetl, lpmode, modsell, refclk_reset, fs
  );

  modport slave (
    output modprsl, intl,
    input  resetl, lpmode, modsell, refclk_reset, fs
  );
endinterface

// File: rtl/qsfp_sync_debounce.sv
// Two-flop synchronizer followed by a stability filter: the output level only
// follows the input after DEBOUNCE_CYCLES consecutive opposite samples.
module qsfp_sync_debounce #(
  parameter int   DEBOUNCE_CYCLES = 1024,
  parameter logic RESET_LEVEL     = 1'b1
) (
  input  logic clock,
  input  logic resetn,
  input  logic din,
  output logic level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      sync  <= {2{RESET_LEVEL}};
      cnt   <= '0;
      level <= RESET_LEVEL;
    end else begin
      sync <= {sync[0], din};
      // Any sample matching the current level restarts the count.
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/qsfp_link_sequencer.sv
// Power-up / hot-plug sequencer for one QSFP28 cage: walks the module through
// refclk reset, module reset, init wait and GT reset before declaring ready.
module qsfp_link_sequencer
  import qsfp_link_pkg::*;
#(
  parameter int         DEBOUNCE_CYCLES    = 1024,
  parameter int         REFCLK_RST_CYCLES  = 256,
  parameter int         MOD_RST_CYCLES     = 1024,
  parameter int         INIT_WAIT_CYCLES   = 65536,
  parameter int         CLK_TIMEOUT_CYCLES = 1048576,
  parameter int         GT_RST_CYCLES      = 128,
  parameter int         RETRY_CYCLES       = 1048576,
  parameter logic [1:0] FS_DEFAULT         = 2'b00
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic                         enable,
  input  logic [1:0]                   fs_sel,
  input  logic                         clock_ok,
  input  logic                         int_clear,
  qsfp_link_sequencer_if.master        qsfp,
  output logic                         gt_reset,
  output logic                         ready,
  output logic                         present,
  output logic                         int_pending,
  output logic                         fault,
  output logic [2:0]                   state
);

  localparam int MAX_CYCLES =
    max_int(max_int(max_int(DEBOUNCE_CYCLES, REFCLK_RST_CYCLES),
                    max_int(MOD_RST_CYCLES, INIT_WAIT_CYCLES)),
            max_int(max_int(CLK_TIMEOUT_CYCLES, GT_RST_CYCLES), RETRY_CYCLES));
  localparam int CW = $clog2(MAX_CYCLES) + 1;

  state_t        state_q, state_next;
  logic [CW-1:0] cnt_q, cnt_next;
  pins_t         pins_q;
  logic [1:0]    fs_q;
  logic          int_pending_q;
  logic [2:0]    intl_sync;
  logic [1:0]    clk_ok_sync;
  logic          modprsl_level;
  logic          clk_ok_s;
  logic          intl_fall;

  qsfp_sync_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .RESET_LEVEL     (1'b1)
  ) u_modprsl_db (
    .clock  (clock),
    .resetn (resetn),
    .din    (qsfp.modprsl),
    .level  (modprsl_level)
  );

  assign present   = ~modprsl_level;
  assign clk_ok_s  = clk_ok_sync[1];
  // intl_sync[2] is the previous synchronized sample, used for edge detect.
  assign intl_fall = intl_sync[2] & ~intl_sync[1];

  always_comb begin
    state_next = state_q;
    if (!present || !enable) begin
      state_next = ST_ABSENT;
    end else begin
      case (state_q)
        ST_ABSENT:     state_next = ST_REFCLK_RST;
        ST_REFCLK_RST: if (cnt_q == '0) state_next = ST_MOD_RST;
        ST_MOD_RST:    if (cnt_q == '0) state_next = ST_INIT_WAIT;
        ST_INIT_WAIT:  if (cnt_q == '0) state_next = ST_CLK_WAIT;
        ST_CLK_WAIT: begin
          if (clk_ok_s)          state_next = ST_GT_RST;
          else if (cnt_q == '0)  state_next = ST_FAULT;
        end
        ST_GT_RST: begin
          if (!clk_ok_s)         state_next = ST_CLK_WAIT;
          else if (cnt_q == '0)  state_next = ST_RUN;
        end
        ST_RUN:        if (!clk_ok_s) state_next = ST_CLK_WAIT;
        ST_FAULT:      if (cnt_q == '0) state_next = ST_REFCLK_RST;
        default:       state_next = ST_ABSENT;
      endcase
    end
  end

  // Timer reloads with N-1 on every state entry so each timed state lasts N cycles.
  always_comb begin
    cnt_next = cnt_q;
    if (state_next != state_q) begin
      case (state_next)
        ST_REFCLK_RST: cnt_next = CW'(REFCLK_RST_CYCLES - 1);
        ST_MOD_RST:    cnt_next = CW'(MOD_RST_CYCLES - 1);
        ST_INIT_WAIT:  cnt_next = CW'(INIT_WAIT_CYCLES - 1);
        ST_CLK_WAIT:   cnt_next = CW'(CLK_TIMEOUT_CYCLES - 1);
        ST_GT_RST:     cnt_next = CW'(GT_RST_CYCLES - 1);
        ST_FAULT:      cnt_next = CW'(RETRY_CYCLES - 1);
        default:       cnt_next = '0;
      endcase
    end else if (cnt_q != '0) begin
      cnt_next = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q       <= ST_ABSENT;
      cnt_q         <= '0;
      pins_q        <= PINS_RESET;
      fs_q          <= FS_DEFAULT;
      int_pending_q <= 1'b0;
      intl_sync     <= 3'b111;
      clk_ok_sync   <= 2'b00;
    end else begin
      state_q     <= state_next;
      cnt_q       <= cnt_next;
      pins_q      <= pins_for(state_next);
      intl_sync   <= {intl_sync[1:0], qsfp.intl};
      clk_ok_sync <= {clk_ok_sync[0], clock_ok};
      if (state_q == ST_ABSENT) fs_q <= fs_sel;
      // Entering ABSENT wipes the flag; otherwise a new interrupt beats a clear.
      if (state_next == ST_ABSENT && state_q != ST_ABSENT) int_pending_q <= 1'b0;
      else if (intl_fall && present)                       int_pending_q <= 1'b1;
      else if (int_clear)                                  int_pending_q <= 1'b0;
    end
  end

  assign qsfp.resetl       = pins_q.resetl;
  assign qsfp.lpmode       = pins_q.lpmode;
  assign qsfp.modsell      = pins_q.modsell;
  assign qsfp.refclk_reset = pins_q.refclk_reset;
  assign qsfp.fs           = fs_q;
  assign gt_reset          = pins_q.gt_reset;
  assign ready             = pins_q.ready;
  assign fault             = pins_q.fault;
  assign int_pending       = int_pending_q;
  assign state             = state_q;

endmodule

// File: tb/tb_qsfp_link_sequencer.sv
// Directed bench for qsfp_link_sequencer with shortened timing parameters;
// every expected value below is hand-derived from the sequencing rules.
module tb_qsfp_link_sequencer;

  // Output bundle order: resetl lpmode modsell refclk_reset gt_reset ready fault state[2:0]
  localparam logic [9:0] O_ABSENT = 10'b0111100_000;
  localparam logic [9:0] O_REFCLK = 10'b0111100_001;
  localparam logic [9:0] O_MODRST = 10'b0110100_010;
  localparam logic [9:0] O_INIT   = 10'b1010100_011;
  localparam logic [9:0] O_CLKW   = 10'b1010100_100;
  localparam logic [9:0] O_GTRST  = 10'b1010100_101;
  localparam logic [9:0] O_RUN    = 10'b1000010_110;
  localparam logic [9:0] O_FAULT  = 10'b1010101_111;

  logic       clock = 1'b0;
  logic       resetn, enable, clock_ok, int_clear;
  logic [1:0] fs_sel;
  logic       gt_reset, ready, present, int_pending, fault;
  logic [2:0] state;
  int         vectors = 0;
  int         miscompares = 0;

  qsfp_link_sequencer_if qsfp_bus ();

  qsfp_link_sequencer #(
    .DEBOUNCE_CYCLES    (3),
    .REFCLK_RST_CYCLES  (4),
    .MOD_RST_CYCLES     (8),
    .INIT_WAIT_CYCLES   (16),
    .CLK_TIMEOUT_CYCLES (32),
    .GT_RST_CYCLES      (5),
    .RETRY_CYCLES       (20),
    .FS_DEFAULT         (2'b00)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .enable      (enable),
    .fs_sel      (fs_sel),
    .clock_ok    (clock_ok),
    .int_clear   (int_clear),
    .qsfp        (qsfp_bus),
    .gt_reset    (gt_reset),
    .ready       (ready),
    .present     (present),
    .int_pending (int_pending),
    .fault       (fault),
    .state       (state)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [9:0] exp);
    check(tag, {22'd0, qsfp_bus.resetl, qsfp_bus.lpmode, qsfp_bus.modsell,
                qsfp_bus.refclk_reset, gt_reset, ready, fault, state}, {22'd0, exp});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; enable = 1'b0; fs_sel = 2'b00; clock_ok = 1'b0; int_clear = 1'b0;
    qsfp_bus.modprsl = 1'b1; qsfp_bus.intl = 1'b1;
    tick(3);
    check_outs("reset_outs", O_ABSENT);
    check("reset_present", present, 0);
    check("reset_int_pending", int_pending, 0);
    check("reset_fs", qsfp_bus.fs, 2'b00);

    resetn = 1'b1; fs_sel = 2'b10;
    tick(1);
    check("fs_latch_absent", qsfp_bus.fs, 2'b10);

    // Insert: present after 2 sync + 3 debounce cycles.
    enable = 1'b1; clock_ok = 1'b1; qsfp_bus.modprsl = 1'b0;
    tick(4); check("present_not_yet", present, 0);
    tick(1); check("present_set", present, 1); check_outs("absent_before_seq", O_ABSENT);
    tick(1); check_outs("refclk_entry", O_REFCLK);
    tick(3); check_outs("refclk_last", O_REFCLK);
    tick(1); check_outs("modrst_entry", O_MODRST);
    tick(7); check_outs("modrst_last", O_MODRST);
    tick(1); check_outs("init_entry", O_INIT);
    tick(15); check_outs("init_last", O_INIT);
    tick(1); check_outs("clkwait_entry", O_CLKW);
    tick(1); check_outs("gtrst_entry", O_GTRST);
    tick(4); check_outs("gtrst_last", O_GTRST);
    tick(1); check_outs("run_entry", O_RUN);

    fs_sel = 2'b01;
    tick(2); check("fs_ignored_in_run", qsfp_bus.fs, 2'b10);

    // Interrupt edge coincident with int_clear: set must win.
    qsfp_bus.intl = 1'b0;
    tick(2); check("int_before_set", int_pending, 0);
    int_clear = 1'b1; qsfp_bus.intl = 1'b1;
    tick(1); int_clear = 1'b0;
    check("int_set_wins", int_pending, 1);
    tick(1); check("int_sticky", int_pending, 1);
    int_clear = 1'b1;
    tick(1); int_clear = 1'b0;
    check("int_cleared", int_pending, 0);
    qsfp_bus.intl = 1'b0;
    tick(2); qsfp_bus.intl = 1'b1;
    tick(1); check("int_rearm", int_pending, 1);

    // clock_ok loss in RUN, then recovery through GT_RST.
    clock_ok = 1'b0;
    tick(2); check_outs("run_before_sync", O_RUN);
    tick(1); check_outs("clkloss_clkwait", O_CLKW);
    clock_ok = 1'b1;
    tick(2); check_outs("clkwait_hold", O_CLKW);
    tick(1); check_outs("clk_back_gtrst", O_GTRST);
    tick(4); check_outs("clk_back_gtrst_last", O_GTRST);
    tick(1); check_outs("clk_back_run", O_RUN);

    // Two-cycle glitch is filtered out.
    qsfp_bus.modprsl = 1'b1;
    tick(2); qsfp_bus.modprsl = 1'b0;
    tick(6); check("glitch2_present", present, 1); check_outs("glitch2_run", O_RUN);

    // Four-cycle removal is accepted and drops to ABSENT.
    qsfp_bus.modprsl = 1'b1;
    tick(4); qsfp_bus.modprsl = 1'b0;
    tick(1); check("glitch4_present", present, 0); check_outs("glitch4_still_run", O_RUN);
    tick(1); check_outs("glitch4_absent", O_ABSENT);
    check("int_cleared_absent", int_pending, 0);
    check("fs_held_until_absent", qsfp_bus.fs, 2'b10);
    tick(1); check("fs_relatch", qsfp_bus.fs, 2'b01);

    // No clock_ok: CLK_WAIT times out into FAULT, then retries.
    clock_ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (state == 3'd1) break;
      tick(1);
    end
    check_outs("refclk_again", O_REFCLK);
    tick(28); check_outs("clkwait_again", O_CLKW);
    tick(31); check_outs("clkwait_timeout_last", O_CLKW);
    tick(1); check_outs("fault_entry", O_FAULT);
    tick(19); check_outs("fault_last", O_FAULT);
    tick(1); check_outs("retry_refclk", O_REFCLK);

    enable = 1'b0;
    tick(1); check_outs("disable_absent", O_ABSENT); check("disable_present", present, 1);

    enable = 1'b1;
    tick(3); check_outs("reenable_refclk", O_REFCLK);
    resetn = 1'b0;
    tick(1); check_outs("midseq_reset", O_ABSENT); check("midseq_reset_present", present, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
